// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Load/store unit sitting between the CPU data-request port and a word-wide
// synchronous RAM. The RAM has 1-cycle registered read data and no byte
// enables, so byte and half stores are done as read-modify-write.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while IDLE)
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10/11 word
//   req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//   req_addr             byte address (bits above RAM_AW+1 are ignored)
//   req_wdata            store data, lane taken from the LSBs
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            extended load data, 0 for stores
//   rsp_err              misaligned-access flag, valid with rsp_valid
//   ram_addr/ram_we/ram_wdata/ram_rdata   word RAM port
//
// Optional feature: define DMEM_MISALIGN_CHK_EN to flag misaligned half/word
// accesses through an ERR state instead of silently ignoring the low bits.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_AW     = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        RMW_RD,
        RMW_MRG,
        RMW_WR
`ifdef DMEM_MISALIGN_CHK_EN
        , ERR
`endif
    } state_t;

    state_t state, state_n;

    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic              capture;

    logic [RAM_AW-1:0] ram_addr_n;
    logic              ram_we_n;
    logic [31:0]       ram_wdata_n;
    logic              rsp_valid_n;
    logic [31:0]       rsp_rdata_n;
    logic              rsp_err_n;

    // Upper address bits are dropped on purpose (address wrap into the RAM).
    logic              addr_hi_unused;
    assign addr_hi_unused = ^req_addr;

    assign req_ready = (state == IDLE);

`ifdef DMEM_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Select the addressed lane and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  size,
                                            input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Overlay the store lane onto the old RAM word; other lanes are kept.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [1:0]  lo,
                                          input logic [1:0]  size);
        logic [31:0] m;
        m = old;
        if (size == 2'b00) begin
            m[8*lo +: 8] = d[7:0];
        end else begin
            m[16*lo[1] +: 16] = d[15:0];
        end
        return m;
    endfunction

    // State and output registers; everything visible to the outside is
    // registered, so this block simply loads the values chosen below.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_lo_q <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            wdata_q   <= 32'h0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            ram_addr  <= ram_addr_n;
            ram_we    <= ram_we_n;
            ram_wdata <= ram_wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            if (capture) begin
                addr_lo_q <= req_addr[1:0];
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                wdata_q   <= req_wdata;
            end
        end
    end

    // Next-state and next-output selection. Strobes (ram_we, rsp_valid,
    // rsp_err) default low so they pulse for exactly one cycle; address,
    // write data and read data hold their last value.
    always_comb begin
        state_n     = state;
        capture     = 1'b0;
        ram_addr_n  = ram_addr;
        ram_we_n    = 1'b0;
        ram_wdata_n = ram_wdata;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
                    if (misaligned) begin
                        state_n = ERR;
                    end else
`endif
                    begin
                        ram_addr_n = req_addr[RAM_AW+1:2];
                        if (!req_we) begin
                            state_n = RD1;
                        end else if (req_size[1]) begin
                            ram_wdata_n = req_wdata;
                            ram_we_n    = 1'b1;
                            state_n     = WR;
                        end else begin
                            state_n = RMW_RD;
                        end
                    end
                end
            end
            WR: begin
                rsp_valid_n = 1'b1;
                rsp_rdata_n = 32'h0;
                state_n     = IDLE;
            end
            RD1:    state_n = RD2;
            RD2: begin
                rsp_rdata_n = extract(ram_rdata, addr_lo_q, size_q, uns_q);
                rsp_valid_n = 1'b1;
                state_n     = IDLE;
            end
            RMW_RD: state_n = RMW_MRG;
            RMW_MRG: begin
                ram_wdata_n = merge(ram_rdata, wdata_q, addr_lo_q, size_q);
                ram_we_n    = 1'b1;
                state_n     = RMW_WR;
            end
            RMW_WR: begin
                rsp_valid_n = 1'b1;
                rsp_rdata_n = 32'h0;
                state_n     = IDLE;
            end
`ifdef DMEM_MISALIGN_CHK_EN
            ERR: begin
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
                rsp_rdata_n = 32'h0;
                state_n     = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: drives requests, models the word RAM, and
// checks responses against a scoreboard of expected results.
module tb_dmem_access_unit;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] ram [0:4095];
   logic [31:0] shadow [0:7];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acceptCycle;
      int          id;
   } exp_t;

   exp_t sbQ[$];

   int vectorCount = 0;
   int missCount = 0;
   int cycle = 0;
   int weRun = 0;
   bit weSeen = 0;
   bit prevValid = 0;
   int lastAccept = 0;
   int nextId = 0;

   dmem_access_unit #(.ADDR_WIDTH(32), .RAM_AW(12)) dut (
      .clk(clk),
      .resetn(resetn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .ram_addr(ram_addr),
      .ram_we(ram_we),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure response latency.
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   // Word RAM with registered read data and no byte enables.
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   // Runaway guard so the bench always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Reference load extraction, written as shift-and-mask.
   function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
      logic [31:0] s;
      if (size == 2'b00) begin
         s = (w >> (8 * addr[1:0])) & 32'hFF;
         if (!uns && s[7]) s = s | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         s = (w >> (16 * addr[1])) & 32'hFFFF;
         if (!uns && s[15]) s = s | 32'hFFFF_0000;
      end else begin
         s = w;
      end
      return s;
   endfunction

   function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] d);
      logic [31:0] mask;
      logic [31:0] sh;
      if (size[1]) return d;
      mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
      sh = (size == 2'b00) ? 32'(8 * addr[1:0]) : 32'(16 * addr[1]);
      return (old & ~(mask << sh)) | ((d & mask) << sh);
   endfunction

   // Present one request, wait (bounded) for it to be accepted, and push the
   // expected response. Returns the number of cycles the request was held off.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData, input logic expErr, input int expLat,
                                input bit expectRsp, output int busy);
      exp_t e;
      int guard;
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      busy = 0;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         busy++;
         guard++;
      end
      if (!req_ready) checkOutput("ready_timeout", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      e.rdata = expData;
      e.err = expErr;
      e.lat = expLat;
      e.acceptCycle = cycle;
      e.id = nextId;
      nextId++;
      lastAccept = cycle;
      if (expectRsp) sbQ.push_back(e);
      req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while (sbQ.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("drain_timeout", sbQ.size(), 32'd0);
   endtask

   // Response monitor: pops the scoreboard on every rsp_valid, and watches
   // the ram_we and rsp_valid pulse widths.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (ram_we) begin
               weSeen = 1'b1;
               weRun++;
            end else if (weRun != 0) begin
               checkOutput("ram_we_width", weRun, 32'd1);
               weRun = 0;
            end
            if (prevValid) checkOutput("rsp_pulse_width", {31'b0, rsp_valid}, 32'd0);
            if (rsp_valid) begin
               if (sbQ.size() == 0) begin
                  checkOutput("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
               end else begin
                  e = sbQ.pop_front();
                  checkOutput($sformatf("rsp_rdata#%0d", e.id), rsp_rdata, e.rdata);
                  checkOutput($sformatf("rsp_err#%0d", e.id), {31'b0, rsp_err}, {31'b0, e.err});
                  checkOutput($sformatf("latency#%0d", e.id), cycle - e.acceptCycle, e.lat);
               end
            end
            prevValid = rsp_valid;
         end else begin
            prevValid = 1'b0;
            weRun = 0;
         end
      end
   end

   // Main sequence: reset, directed loads/stores, back-to-back, reset in the
   // middle of a read-modify-write, wrap-around, then a random mix.
   initial begin
      int busy;
      int swAccept;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [31:0] wd;
      logic        un;
      int          wi;

      for (int i = 0; i < 4096; i++) ram[i] = 32'h1000_0000 + i;
      ram[12'h845] = 32'h00ff00ff;
      ram[12'h823] = 32'hff00ff00;
      for (int i = 0; i < 8; i++) shadow[i] = 32'h1000_0100 + i;

      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #1;
      checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
      checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("rst_ram_addr", {20'b0, ram_addr}, 32'd0);
      checkOutput("rst_ram_we", {31'b0, ram_we}, 32'd0);
      checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Directed loads.
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h2114, 32'h0, 32'hffffffff, 1'b0, 2, 1'b1, busy);
      waitDrain();
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h2114, 32'h0, 32'h000000ff, 1'b0, 2, 1'b1, busy);
      waitDrain();
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h208E, 32'h0, 32'hffffff00, 1'b0, 2, 1'b1, busy);
      waitDrain();
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h208E, 32'h0, 32'h0000ff00, 1'b0, 2, 1'b1, busy);
      waitDrain();
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h208C, 32'h0, 32'hff00ff00, 1'b0, 2, 1'b1, busy);
      waitDrain();

      // Misaligned word load.
      weSeen = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h2115, 32'h0, 32'h0, 1'b1, 1, 1'b1, busy);
`else
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h2115, 32'h0, 32'h00ff00ff, 1'b0, 2, 1'b1, busy);
`endif
      waitDrain();
      checkOutput("misalign_no_write", {31'b0, weSeen}, 32'd0);
      checkOutput("misalign_ram", ram[12'h845], 32'h00ff00ff);

      // Reset while the read-modify-write is in its merge cycle.
      weSeen = 1'b0;
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h2114, 32'h000000AB, 32'h0, 1'b0, 3, 1'b0, busy);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("midrst_ram_we", {31'b0, ram_we}, 32'd0);
      checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      #2 resetn = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("midrst_no_write", {31'b0, weSeen}, 32'd0);
      checkOutput("midrst_ram", ram[12'h845], 32'h00ff00ff);
      checkOutput("midrst_ready", {31'b0, req_ready}, 32'd1);

      // Sub-word stores.
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h2116, 32'h123456AB, 32'h0, 1'b0, 3, 1'b1, busy);
      waitDrain();
      checkOutput("sb_ram", ram[12'h845], 32'h00ab00ff);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h2114, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1, busy);
      waitDrain();
      checkOutput("sh_ram", ram[12'h845], 32'h00abbeef);

      // Back-to-back: store then load with valid held across the busy cycle.
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111, 32'h0, 1'b0, 1, 1'b1, busy);
      swAccept = lastAccept;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0, 2, 1'b1, busy);
      checkOutput("b2b_busy", busy, 32'd1);
      checkOutput("b2b_accept", lastAccept - swAccept, 32'd2);
      waitDrain();

      // Address wrap into the top word.
      applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1, busy);
      waitDrain();
      checkOutput("wrap_ram", ram[12'hFFF], 32'hCAFEF00D);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1, busy);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0000CAFE, 1'b0, 2, 1'b1, busy);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000000D, 1'b0, 2, 1'b1, busy);
      waitDrain();

      // Random aligned mix over words 0x100..0x107, issued back to back.
      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(0, 3));
         wi = $urandom_range(0, 7);
         ad = 32'h400 + 32'(wi * 4);
         if (sz == 2'b00) ad = ad + 32'($urandom_range(0, 3));
         else if (sz == 2'b01) ad = ad + 32'(2 * $urandom_range(0, 1));
         un = 1'($urandom_range(0, 1));
         wd = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            shadow[wi] = modelStore(shadow[wi], ad, sz, wd);
            applyStimulus(1'b1, sz, un, ad, wd, 32'h0, 1'b0, sz[1] ? 1 : 3, 1'b1, busy);
         end else begin
            applyStimulus(1'b0, sz, un, ad, wd, modelLoad(shadow[wi], ad, sz, un), 1'b0, 2, 1'b1, busy);
         end
      end
      waitDrain();
      for (int i = 0; i < 8; i++) checkOutput($sformatf("rand_ram[%0d]", i), ram[12'h100 + i], shadow[i]);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
